key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Consumes the clean, debounced key level produced by the board's key-debounce stage.
- Turns that level into one-cycle control events for the display and counter logic:
  - press
  - release
  - long-press
  - auto-repeat while held
- Also tracks a wrapping press counter and a held flag.
- Sits between the debouncer output and the application FSMs; one instance per key.

Parameters:
- ACTIVE_HIGH, 1: 1 means key_in=1 is pressed; 0 means key_in=0 is pressed.
- LONG_CNT, 100000000: cycles from press to long_press (1 s at 100 MHz); legal range ≥2.
- REPEAT_CNT, 20000000: cycles between successive repeat pulses after long_press (200 ms); legal range ≥2.
- CNT_W, 27: hold-counter width; must satisfy 2^CNT_W > max(LONG_CNT, REPEAT_CNT).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- key_in  in  1  debounced key level.
- press  out  1  one-cycle pulse on press.
- release  out  1  one-cycle pulse on release.
- long_press  out  1  one-cycle pulse when held LONG_CNT cycles.
- repeat  out  1  one-cycle pulse every REPEAT_CNT cycles after long_press.
- held  out  1  level: key currently pressed, as seen by the FSM.
- press_cnt  out  8  number of presses since reset, modulo 256.

Behaviour:
- Reset (rst=0 sampled at posedge):
  - state=IDLE, key_q=0, hold counter=0.
  - press, release, long_press, repeat, held all 0; press_cnt=0.
  - Reset overrides all other activity, including mid-hold.
- Pressed-level detection:
  - p = key_in when ACTIVE_HIGH=1, else ~key_in.
  - key_q <= p every cycle.
  - rise = p & ~key_q; fall = ~p & key_q.
- All outputs are registered. Pulse outputs default to 0 every cycle unless set below.
- State IDLE:
  - On rise: press=1, press_cnt += 1 (wraps 255→0), cnt=0, held=1, go to PRESSED.
- State PRESSED:
  - On fall: release=1, held=0, go to IDLE.
  - Else if cnt == LONG_CNT-1: long_press=1, cnt=0, go to REPEAT.
  - Else cnt += 1.
- State REPEAT:
  - On fall: release=1, held=0, go to IDLE.
  - Else if cnt == REPEAT_CNT-1: repeat=1, cnt=0.
  - Else cnt += 1.
- Timing:
  - press asserts at the first posedge sampling p=1.
  - long_press asserts exactly LONG_CNT cycles after press.
  - Repeat pulses follow at REPEAT_CNT-cycle spacing.
  - release asserts at the first posedge sampling p=0.
- Simultaneous events:
  - fall in the same cycle as a count terminal: release wins; no long_press or repeat is issued.
  - At most one of press/release/long_press/repeat is high in any cycle.
- A rise outside IDLE, or a fall in IDLE, is ignored. This cannot occur given key_q tracking; it is a defensive rule.
- Key held pressed through reset deassertion: key_q=0 after reset, so the first cycle after reset produces press.
- Short tap (press then release before LONG_CNT): press and release only; no long_press.

Test Plan (LONG_CNT=10, REPEAT_CNT=4, ACTIVE_HIGH=1 unless noted):
- Reset, key_in=0 for 20 cycles → all pulses 0, held=0, press_cnt=0.
- key_in 0→1 held 5 cycles, then 1→0 → press at cycle 0; release at cycle 5; no long_press; held high exactly cycles 0–4; press_cnt=1.
- key_in held high 25 cycles → press at 0; long_press at 10; repeat at 14, 18, 22; release one cycle after key_in drops.
- key_in falls at the exact cycle the counter reaches LONG_CNT-1 → release only; long_press never asserts; state IDLE.
- 257 short taps → press_cnt=1 at the end (wrap 255→0→1); one press and one release pulse per tap.
- rst=0 applied mid-REPEAT with key_in held high, released after 3 cycles → outputs 0 during reset; press on the first cycle after release; long_press 10 cycles later.
- ACTIVE_HIGH=0, key_in 1→0→1 → press on the fall, release on the rise.

Source files
------------

// File: rtl/key_event_decoder.sv
// Per-key event decoder: turns a debounced key level into one-cycle press, release,
// long-press and auto-repeat pulses, plus a held level and a wrapping press counter.
module key_event_decoder #(
  parameter bit          ACTIVE_HIGH = 1'b1,
  parameter int unsigned LONG_CNT    = 100000000,
  parameter int unsigned REPEAT_CNT  = 20000000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_REPEAT
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q;
  logic             p, rise, fall;
  logic             press_d, release_d, long_d, repeat_d, held_d;
  logic [7:0]       press_cnt_d;

  assign p    = ACTIVE_HIGH ? key_in : ~key_in;
  assign rise = p & ~key_q;
  assign fall = ~p & key_q;

  // NOTE: every output of this block gets a default before the case, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    held_d      = held;
    press_cnt_d = press_cnt;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d     = 1'b1;
          press_cnt_d = press_cnt + 8'd1;
          cnt_d       = '0;
          held_d      = 1'b1;
          state_d     = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        // A fall on the terminal cycle wins: the key is gone, so no long_press.
        if (fall) begin
          release_d = 1'b1;
          held_d    = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          release_d = 1'b1;
          held_d    = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_q         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_cnt     <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_q         <= p;
      press         <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
      press_cnt     <= press_cnt_d;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_CNT=10, REPEAT_CNT=4; one active-high
// and one active-low instance share clock and reset.
module tb_key_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_hi, key_lo;
  logic       press_hi, rel_hi, long_hi, rep_hi, held_hi;
  logic       press_lo, rel_lo, long_lo, rep_lo, held_lo;
  logic [7:0] cnt_hi, cnt_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_event_decoder #(.ACTIVE_HIGH(1'b1), .LONG_CNT(10), .REPEAT_CNT(4), .CNT_W(8)) u_hi (
    .clk(clk), .rst(rst), .key_in(key_hi),
    .press(press_hi), .release_pulse(rel_hi), .long_press(long_hi),
    .repeat_pulse(rep_hi), .held(held_hi), .press_cnt(cnt_hi)
  );

  key_event_decoder #(.ACTIVE_HIGH(1'b0), .LONG_CNT(10), .REPEAT_CNT(4), .CNT_W(8)) u_lo (
    .clk(clk), .rst(rst), .key_in(key_lo),
    .press(press_lo), .release_pulse(rel_lo), .long_press(long_lo),
    .repeat_pulse(rep_lo), .held(held_lo), .press_cnt(cnt_lo)
  );

  // Bit order: {press, release, long_press, repeat, held}
  logic [4:0] v_hi, v_lo;
  assign v_hi = {press_hi, rel_hi, long_hi, rep_hi, held_hi};
  assign v_lo = {press_lo, rel_lo, long_lo, rep_lo, held_lo};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] vec(input bit pr, input bit rl, input bit lg,
                                     input bit rp, input bit hd);
    return {pr, rl, lg, rp, hd};
  endfunction

  initial begin
    rst    = 1'b0;
    key_hi = 1'b0;
    key_lo = 1'b1;
    repeat (3) tick();
    check("reset_vec", v_hi, 5'b0);
    check("reset_cnt", cnt_hi, 8'd0);
    rst = 1'b1;

    // Idle after reset
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_hi", v_hi, 5'b0);
      check("idle_cnt", cnt_hi, 8'd0);
      check("idle_lo", v_lo, 5'b0);
    end

    // Short tap: high for edges 0..4, low at edge 5
    for (int c = 0; c <= 5; c++) begin
      key_hi = (c < 5);
      tick();
      check("tap_vec", v_hi, vec(c == 0, c == 5, 1'b0, 1'b0, c < 5));
    end
    check("tap_cnt", cnt_hi, 8'd1);
    repeat (3) tick();

    // Long hold of 25 cycles: long at 10, repeats at 14/18/22, release at 25
    for (int c = 0; c <= 25; c++) begin
      key_hi = (c < 25);
      tick();
      check("hold_vec", v_hi, vec(c == 0, c == 25, c == 10,
                                  (c == 14) || (c == 18) || (c == 22), c < 25));
    end
    check("hold_cnt", cnt_hi, 8'd2);
    repeat (3) tick();

    // Fall on the cycle the counter would reach its terminal: release only
    for (int c = 0; c <= 10; c++) begin
      key_hi = (c < 10);
      tick();
      check("term_vec", v_hi, vec(c == 0, c == 10, 1'b0, 1'b0, c < 10));
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      check("term_idle", v_hi, 5'b0);
    end
    check("term_cnt", cnt_hi, 8'd3);

    // 257 taps from a fresh reset: counter wraps 255 -> 0 -> 1
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("wrap_start", cnt_hi, 8'd0);
    for (int t = 1; t <= 257; t++) begin
      key_hi = 1'b1;
      tick();
      check("wrap_press", v_hi, vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      key_hi = 1'b0;
      tick();
      check("wrap_rel", v_hi, vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      if (t == 255) check("wrap_255", cnt_hi, 8'd255);
      if (t == 256) check("wrap_0", cnt_hi, 8'd0);
    end
    check("wrap_end", cnt_hi, 8'd1);

    // Reset mid-REPEAT with the key still held
    key_hi = 1'b1;
    for (int c = 0; c <= 12; c++) tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid_rst_vec", v_hi, 5'b0);
      check("mid_rst_cnt", cnt_hi, 8'd0);
    end
    rst = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      tick();
      check("post_rst_vec", v_hi, vec(c == 0, 1'b0, c == 10, 1'b0, 1'b1));
    end
    check("post_rst_cnt", cnt_hi, 8'd1);
    key_hi = 1'b0;
    tick();
    check("post_rst_rel", v_hi, vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    // Active-low instance: press on the fall of key_in, release on the rise
    for (int c = 0; c <= 3; c++) begin
      key_lo = (c < 3) ? 1'b0 : 1'b1;
      tick();
      check("lo_vec", v_lo, vec(c == 0, c == 3, 1'b0, 1'b0, c < 3));
    end
    check("lo_cnt", cnt_lo, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
